// File: rtl/off_on_switch_if.sv
// Off/on switch port bundle: timer inputs from the sequencer, switch drives back out.
interface off_on_switch_if;
    logic       state_start;
    logic [4:0] count;
    logic       sw_off;
    logic       sw_on;
    logic       off_on_done;
    logic       seq_err;

    modport master (
        output state_start, count,
        input  sw_off, sw_on, off_on_done, seq_err
    );

    modport slave (
        input  state_start, count,
        output sw_off, sw_on, off_on_done, seq_err
    );
endinterface

// File: rtl/off_on_switch.sv
// T/R switch sequencer: sw_off from count==OFF_POINT, sw_on for ON_WIDTH cycles from count==ON_POINT.
// Latency: every output registered, one clk_sys edge after the deciding sample.
// No backpressure; optional dead time between phases under macro OFF_ON_DEADTIME_EN.
module off_on_switch #(
    parameter logic [4:0] OFF_POINT = 5'd4,
    parameter logic [4:0] ON_POINT  = 5'd20,
    parameter logic [7:0] ON_WIDTH  = 8'd16,
    parameter logic [3:0] DEADTIME  = 4'd2
) (
    input  logic          clk_sys,
    input  logic          rst_n,
    off_on_switch_if.slave sw
);
    localparam logic PARAMS_OK = (ON_POINT > OFF_POINT);

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        OFF_ACT,
`ifdef OFF_ON_DEADTIME_EN
        DEAD,
`endif
        ON_ACT,
        DONE
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       start_q;
    logic       hist_vld;
    logic       start_rise;
    logic [7:0] on_cnt;
    logic [7:0] on_cnt_nxt;
    logic       off_q;
    logic       on_q;
    logic       done_q;
    logic       err_q;
    logic       off_nxt;
    logic       on_nxt;
    logic       done_nxt;
    logic       err_nxt;

`ifdef OFF_ON_DEADTIME_EN
    logic [3:0] dead_cnt;
    logic [3:0] dead_cnt_nxt;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            dead_cnt <= 4'd0;
        end else begin
            dead_cnt <= dead_cnt_nxt;
        end
    end
`else
    logic unused_deadtime;
    assign unused_deadtime = ^DEADTIME;
`endif

    // hist_vld stops a start already high at reset release from looking like a rising edge
    assign start_rise = sw.state_start & ~start_q & hist_vld;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            start_q  <= 1'b0;
            hist_vld <= 1'b0;
            on_cnt   <= 8'd0;
            off_q    <= 1'b0;
            on_q     <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            start_q  <= sw.state_start;
            hist_vld <= 1'b1;
            on_cnt   <= on_cnt_nxt;
            off_q    <= off_nxt;
            on_q     <= on_nxt;
            done_q   <= done_nxt;
            err_q    <= err_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        on_cnt_nxt = on_cnt;
        off_nxt    = 1'b0;
        on_nxt     = 1'b0;
        done_nxt   = 1'b0;
        err_nxt    = 1'b0;
`ifdef OFF_ON_DEADTIME_EN
        dead_cnt_nxt = dead_cnt;
`endif
        case (state)
            IDLE: begin
                on_cnt_nxt = 8'd0;
`ifdef OFF_ON_DEADTIME_EN
                dead_cnt_nxt = 4'd0;
`endif
                if (start_rise) begin
                    if (PARAMS_OK) begin
                        state_nxt = ARMED;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            ARMED: begin
                if (!sw.state_start) begin
                    state_nxt = IDLE;
                end else if (sw.count == OFF_POINT) begin
                    state_nxt = OFF_ACT;
                    off_nxt   = 1'b1;
                end
            end
            OFF_ACT: begin
                off_nxt = 1'b1;
                if (!sw.state_start) begin
                    state_nxt = IDLE;
                    off_nxt   = 1'b0;
                    err_nxt   = 1'b1;
                end else if (sw.count == ON_POINT) begin
                    off_nxt = 1'b0;
`ifdef OFF_ON_DEADTIME_EN
                    state_nxt    = DEAD;
                    dead_cnt_nxt = 4'd1;
`else
                    state_nxt  = ON_ACT;
                    on_nxt     = 1'b1;
                    on_cnt_nxt = 8'd1;
`endif
                end else if (sw.count == 5'd0) begin
                    // timer restarted (or wrapped) before ON_POINT
                    state_nxt = IDLE;
                    off_nxt   = 1'b0;
                    err_nxt   = 1'b1;
                end
            end
`ifdef OFF_ON_DEADTIME_EN
            DEAD: begin
                if (!sw.state_start) begin
                    state_nxt = IDLE;
                    err_nxt   = 1'b1;
                end else if (dead_cnt >= DEADTIME) begin
                    state_nxt  = ON_ACT;
                    on_nxt     = 1'b1;
                    on_cnt_nxt = 8'd1;
                end else if (dead_cnt != 4'hF) begin
                    dead_cnt_nxt = dead_cnt + 4'd1;
                end
            end
`endif
            ON_ACT: begin
                on_nxt = 1'b1;
                if (!sw.state_start) begin
                    state_nxt = IDLE;
                    on_nxt    = 1'b0;
                    err_nxt   = 1'b1;
                end else if (on_cnt >= ON_WIDTH) begin
                    state_nxt = DONE;
                    on_nxt    = 1'b0;
                    done_nxt  = 1'b1;
                end else if (on_cnt != 8'hFF) begin
                    on_cnt_nxt = on_cnt + 8'd1;
                end
            end
            DONE: begin
                state_nxt  = IDLE;
                on_cnt_nxt = 8'd0;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign sw.sw_off      = off_q;
    assign sw.sw_on       = on_q;
    assign sw.off_on_done = done_q;
    assign sw.seq_err     = err_q;
endmodule

// File: tb/tb_off_on_switch.sv
// Bench for off_on_switch: vector table, directed corner sequences and random stimulus vs a phase model.
`timescale 1ns/1ps
module tb_off_on_switch;
    localparam int OFF_P = 4;
    localparam int ON_P  = 20;
    localparam int ON_W  = 16;
`ifdef OFF_ON_DEADTIME_EN
    localparam int DT = 2;
`else
    localparam int DT = 0;
`endif
    localparam int P_IDLE  = 0;
    localparam int P_ARMED = 1;
    localparam int P_OFF   = 2;
    localparam int P_DEAD  = 3;
    localparam int P_ON    = 4;
    localparam int P_DONE  = 5;

    typedef struct {
        bit         st;
        logic [4:0] c;
        bit   [3:0] exp;   // {sw_off, sw_on, off_on_done, seq_err}
    } vec_t;

    logic clk_sys = 1'b0;
    logic rst_n;

    off_on_switch_if tif ();
    off_on_switch_if bif ();

    off_on_switch dut (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .sw      (tif.slave)
    );

    off_on_switch #(
        .OFF_POINT (5'd20),
        .ON_POINT  (5'd4)
    ) dut_bad (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .sw      (bif.slave)
    );

    always #5 clk_sys = ~clk_sys;

    int checks   = 0;
    int failures = 0;

    // phase model: which phase we are in and how many cycles of it remain
    int m_phase;
    int m_left;
    bit m_prev, m_pv, m_err, m_done;
    bit b_prev, b_pv, b_err;

    int t_off, t_on, t_done, t_err, stepn;
    int first_off_cnt, last_off_cnt, last_off_step, first_on_step;

    vec_t tbl [23];

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, exp);
        end
    endtask

    function automatic vec_t v(bit st, int c, bit [3:0] e);
        vec_t r;
        r.st  = st;
        r.c   = 5'(c);
        r.exp = e;
        return r;
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE;
        m_left  = 0;
        m_prev  = 1'b0;
        m_pv    = 1'b0;
        m_err   = 1'b0;
        m_done  = 1'b0;
        b_prev  = 1'b0;
        b_pv    = 1'b0;
        b_err   = 1'b0;
    endtask

    task automatic clear_tally();
        t_off = 0; t_on = 0; t_done = 0; t_err = 0; stepn = 0;
        first_off_cnt = -1; last_off_cnt = -1; last_off_step = -1; first_on_step = -1;
    endtask

    task automatic model_edge(bit st, int c);
        bit rise;
        rise   = st && !m_prev && m_pv;
        m_prev = st;
        m_pv   = 1'b1;
        m_err  = 1'b0;
        m_done = 1'b0;
        b_err  = st && !b_prev && b_pv;
        b_prev = st;
        b_pv   = 1'b1;
        case (m_phase)
            P_IDLE:  if (rise) m_phase = P_ARMED;
            P_ARMED: begin
                if (!st) m_phase = P_IDLE;
                else if (c == OFF_P) m_phase = P_OFF;
            end
            P_OFF: begin
                if (!st) begin
                    m_phase = P_IDLE; m_err = 1'b1;
                end else if (c == ON_P) begin
                    if (DT > 0) begin m_phase = P_DEAD; m_left = DT; end
                    else begin m_phase = P_ON; m_left = ON_W; end
                end else if (c == 0) begin
                    m_phase = P_IDLE; m_err = 1'b1;
                end
            end
            P_DEAD: begin
                if (!st) begin
                    m_phase = P_IDLE; m_err = 1'b1;
                end else begin
                    m_left--;
                    if (m_left == 0) begin m_phase = P_ON; m_left = ON_W; end
                end
            end
            P_ON: begin
                if (!st) begin
                    m_phase = P_IDLE; m_err = 1'b1;
                end else begin
                    m_left--;
                    if (m_left == 0) begin m_phase = P_DONE; m_done = 1'b1; end
                end
            end
            default: m_phase = P_IDLE;
        endcase
    endtask

    task automatic step(bit st, logic [4:0] c);
        @(negedge clk_sys);
        tif.state_start = st;
        tif.count       = c;
        bif.state_start = st;
        bif.count       = c;
        model_edge(st, int'(c));
        @(posedge clk_sys);
        #1;
        stepn++;
        chk("sw_off",       int'(tif.sw_off),      int'(m_phase == P_OFF));
        chk("sw_on",        int'(tif.sw_on),       int'(m_phase == P_ON));
        chk("off_on_done",  int'(tif.off_on_done), int'(m_done));
        chk("seq_err",      int'(tif.seq_err),     int'(m_err));
        chk("no_overlap",   int'(tif.sw_off & tif.sw_on), 0);
        chk("bad_seq_err",  int'(bif.seq_err),     int'(b_err));
        chk("bad_switches", int'({bif.sw_off, bif.sw_on, bif.off_on_done}), 0);
        if (tif.sw_off) begin
            t_off++;
            if (first_off_cnt < 0) first_off_cnt = int'(c);
            last_off_cnt  = int'(c);
            last_off_step = stepn;
        end
        if (tif.sw_on) begin
            t_on++;
            if (first_on_step < 0) first_on_step = stepn;
        end
        t_done += int'(tif.off_on_done);
        t_err  += int'(tif.seq_err);
    endtask

    initial begin
        int  cnt;
        bit  st;
        localparam bit [3:0] R16 = (DT > 0) ? 4'b0000 : 4'b0100;

        tbl = '{v(0, 0, 4'b0000), v(1, 4, 4'b0000), v(1, 20, 4'b0000), v(1, 0, 4'b0000),
                v(1, 4, 4'b1000), v(1, 5, 4'b1000), v(1, 0, 4'b0001), v(1, 4, 4'b0000),
                v(0, 4, 4'b0000), v(1, 3, 4'b0000), v(0, 4, 4'b0000), v(1, 0, 4'b0000),
                v(1, 4, 4'b1000), v(0, 5, 4'b0001), v(1, 0, 4'b0000), v(1, 4, 4'b1000),
                v(1, 20, R16),    v(0, 21, 4'b0001), v(0, 0, 4'b0000), v(1, 0, 4'b0000),
                v(1, 4, 4'b1000), v(1, 31, 4'b1000), v(1, 0, 4'b0001)};

        rst_n = 1'b0;
        tif.state_start = 1'b0; tif.count = 5'd0;
        bif.state_start = 1'b0; bif.count = 5'd0;
        model_reset();
        clear_tally();
        repeat (2) @(posedge clk_sys);
        #1;
        chk("rst_sw_off",  int'(tif.sw_off), 0);
        chk("rst_sw_on",   int'(tif.sw_on), 0);
        chk("rst_done",    int'(tif.off_on_done), 0);
        chk("rst_seq_err", int'(tif.seq_err), 0);
        rst_n = 1'b1;

        for (int i = 0; i < $size(tbl); i++) begin
            step(tbl[i].st, tbl[i].c);
            chk($sformatf("vec%0d_sw_off", i),  int'(tif.sw_off),      int'(tbl[i].exp[3]));
            chk($sformatf("vec%0d_sw_on", i),   int'(tif.sw_on),       int'(tbl[i].exp[2]));
            chk($sformatf("vec%0d_done", i),    int'(tif.off_on_done), int'(tbl[i].exp[1]));
            chk($sformatf("vec%0d_seq_err", i), int'(tif.seq_err),     int'(tbl[i].exp[0]));
        end

        // full off/on cycle with the timer running 0..31 and wrapping
        step(0, 0);
        clear_tally();
        for (int i = 0; i < 45; i++) step(1, 5'(i));
        step(0, 0);
        chk("full_off_cycles", t_off, 16);
        chk("full_off_first",  first_off_cnt, OFF_P);
        chk("full_off_last",   last_off_cnt, ON_P - 1);
        chk("full_on_cycles",  t_on, ON_W);
        chk("full_gap",        first_on_step - last_off_step - 1, DT);
        chk("full_done",       t_done, 1);
        chk("full_err",        t_err, 0);

        // abort: count reaches 10 then drops to 0 while switched off
        step(0, 0);
        clear_tally();
        for (int i = 0; i <= 10; i++) step(1, 5'(i));
        step(1, 0);
        chk("abort_sw_off", int'(tif.sw_off), 0);
        chk("abort_err",    t_err, 1);
        chk("abort_done",   t_done, 0);
        step(1, 1);

        // state_start drops five cycles into the on phase
        step(0, 0);
        clear_tally();
        for (int i = 0; i <= 24 + DT; i++) step(1, 5'(i));
        chk("midon_on_cycles", t_on, 5);
        step(0, 0);
        chk("midon_sw_on", int'(tif.sw_on), 0);
        chk("midon_err",   t_err, 1);
        chk("midon_done",  t_done, 0);
        step(0, 0);

        // asynchronous reset while sw_off is high, released with state_start still high
        for (int i = 0; i <= 6; i++) step(1, 5'(i));
        chk("pre_rst_sw_off", int'(tif.sw_off), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_sw_off",  int'(tif.sw_off), 0);
        chk("arst_sw_on",   int'(tif.sw_on), 0);
        chk("arst_done",    int'(tif.off_on_done), 0);
        chk("arst_seq_err", int'(tif.seq_err), 0);
        model_reset();
        rst_n = 1'b1;
        clear_tally();
        for (int i = 7; i < 45; i++) step(1, 5'(i));
        chk("norearm_off", t_off, 0);
        chk("norearm_on",  t_on, 0);
        chk("norearm_err", t_err, 0);

        // random timer-like stimulus with restarts and jumps
        st  = 1'b0;
        cnt = 0;
        for (int n = 0; n < 1500; n++) begin
            int k;
            if (!st) st = ($urandom_range(0, 3) == 0);
            else if ($urandom_range(0, 99) == 0) st = 1'b0;
            k = int'($urandom_range(0, 99));
            if (!st) cnt = 0;
            else if (k < 2) cnt = 0;
            else if (k == 2) cnt = int'($urandom_range(0, 31));
            else cnt = (cnt + 1) % 32;
            step(st, 5'(cnt));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
